// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out,
// one response back (with timeout error). All outputs registered.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic            cyc_n, stb_n, we_n, rsp_valid_n, rsp_err_n, ready_n;
  logic [3:0]      sel_n;
  logic [31:0]     adr_n, dat_n, rsp_dat_n;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cyc_n       = wbm_cyc_o;
    stb_n       = wbm_stb_o;
    we_n        = wbm_we_o;
    sel_n       = wbm_sel_o;
    adr_n       = wbm_adr_o;
    dat_n       = wbm_dat_o;
    rsp_valid_n = rsp_valid_o;
    rsp_err_n   = rsp_err_o;
    rsp_dat_n   = rsp_dat_o;
    case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_n    = cmd_we_i;
          adr_n   = cmd_adr_i;
          dat_n   = cmd_dat_i;
          sel_n   = cmd_sel_i;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          cnt_n   = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        // ack is checked first so an ack on the timeout edge still completes cleanly
        if (wbm_ack_i) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          we_n        = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_dat_n   = wbm_we_o ? 32'h0 : wbm_dat_i;
          state_n     = RESP;
        end else if (cnt == LAST) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          we_n        = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_dat_n   = 32'h0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cmd_ready_o <= ready_n;
      rsp_valid_o <= rsp_valid_n;
      rsp_err_o   <= rsp_err_n;
      rsp_dat_o   <= rsp_dat_n;
      wbm_cyc_o   <= cyc_n;
      wbm_stb_o   <= stb_n;
      wbm_we_o    <= we_n;
      wbm_sel_o   <= sel_n;
      wbm_adr_o   <= adr_n;
      wbm_dat_o   <= dat_n;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: expected responses queued at command time,
// popped and compared when the DUT presents them.
module tb_wb_cmd_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;

  typedef struct packed {logic err; logic [31:0] dat;} rsp_t;
  rsp_t sb[$];
  int checks = 0;
  int failures = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rsp_pop(input string tag);
    rsp_t e;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, "_dat"}, rsp_dat, e.dat);
    end
  endtask

  task automatic cmd(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk({tag, "_cyc"}, 32'(cyc), 32'd1);
    chk({tag, "_stb"}, 32'(stb), 32'd1);
    chk({tag, "_we"}, 32'(we), 32'(w));
    chk({tag, "_adr"}, adr, a);
    chk({tag, "_wdat"}, wdat, d);
    chk({tag, "_sel"}, 32'(sel), 32'(s));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    int   n;
    rsp_t e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b1; ack = 1'b0; rdat = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);

    // zero-wait write
    sb.push_back('{err: 1'b0, dat: 32'h0});
    cmd("w0", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    ack = 1'b1; rdat = 32'h7777_7777;
    step();
    ack = 1'b0;
    chk("w0_cyc_drop", 32'(cyc), 32'd0);
    chk("w0_we_drop", 32'(we), 32'd0);
    chk("w0_adr_hold", adr, 32'h3000_0004);
    rsp_pop("w0_rsp");
    step();
    chk("w0_rsp_clear", 32'(rsp_valid), 32'd0);
    chk("w0_ready_back", 32'(cmd_ready), 32'd1);

    // 3-wait read
    sb.push_back('{err: 1'b0, dat: 32'h1234_5678});
    cmd("r3", 1'b0, 32'h3000_0100, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("r3_cyc_wait", 32'(cyc), 32'd1);
      chk("r3_ready_wait", 32'(cmd_ready), 32'd0);
      step();
    end
    chk("r3_cyc_c4", 32'(cyc), 32'd1);
    ack = 1'b1; rdat = 32'h1234_5678;
    step();
    ack = 1'b0; rdat = 32'hFFFF_FFFF;
    chk("r3_cyc_drop", 32'(cyc), 32'd0);
    rsp_pop("r3_rsp");
    step();

    // timeout, then a stray ack
    sb.push_back('{err: 1'b1, dat: 32'h0});
    cmd("to", 1'b0, 32'h3000_0200, 32'h0, 4'h1);
    n = 0;
    for (int i = 0; i < 20 && cyc; i++) begin
      n++;
      step();
    end
    chk("to_cyc_len", 32'(n), 32'd8);
    rsp_pop("to_rsp");
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("to_stray_rsp", 32'(rsp_valid), 32'd0);
    chk("to_stray_cyc", 32'(cyc), 32'd0);
    chk("to_stray_ready", 32'(cmd_ready), 32'd1);

    // ack on the timeout edge
    sb.push_back('{err: 1'b0, dat: 32'hCAFE_F00D});
    cmd("tk", 1'b0, 32'h3000_0300, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) step();
    chk("tk_cyc_c8", 32'(cyc), 32'd1);
    ack = 1'b1; rdat = 32'hCAFE_F00D;
    step();
    ack = 1'b0; rdat = 32'h0;
    rsp_pop("tk_rsp");
    step();

    // response backpressure
    rsp_ready = 1'b0;
    sb.push_back('{err: 1'b0, dat: 32'hA5A5_0001});
    cmd("bp", 1'b0, 32'h3000_0400, 32'h0, 4'hC);
    ack = 1'b1; rdat = 32'hA5A5_0001;
    step();
    ack = 1'b0; rdat = 32'h0;
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp_dat_hold", rsp_dat, e.dat);
      chk("bp_err_hold", 32'(rsp_err), 32'(e.err));
      chk("bp_ready_low", 32'(cmd_ready), 32'd0);
      chk("bp_no_accept", 32'(cyc), 32'd0);
      cmd_valid = (i == 1); cmd_adr = 32'h0000_9999;
      step();
      cmd_valid = 1'b0;
    end
    chk("bp_no_accept_end", 32'(cyc), 32'd0);
    rsp_pop("bp_rsp");
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h4000_0010;
    cmd_dat = 32'h0000_0055; cmd_sel = 4'h3;
    step();
    chk("bp_hs_cyc", 32'(cyc), 32'd0);
    chk("bp_hs_rsp", 32'(rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bp_next_cyc", 32'(cyc), 32'd1);
    chk("bp_next_adr", adr, 32'h4000_0010);
    chk("bp_next_we", 32'(we), 32'd1);
    sb.push_back('{err: 1'b0, dat: 32'h0});
    ack = 1'b1;
    step();
    ack = 1'b0;
    rsp_pop("bp_next_rsp");
    step();

    // reset mid-BUS
    cmd("rb", 1'b1, 32'h3000_0500, 32'h1111_2222, 4'hF);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rb_cyc", 32'(cyc), 32'd0);
    chk("rb_stb", 32'(stb), 32'd0);
    chk("rb_rsp", 32'(rsp_valid), 32'd0);
    chk("rb_ready", 32'(cmd_ready), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rb_stray_rsp", 32'(rsp_valid), 32'd0);
    chk("rb_stray_ready", 32'(cmd_ready), 32'd1);
    sb.push_back('{err: 1'b0, dat: 32'h0BAD_F00D});
    cmd("ra", 1'b0, 32'h3000_0600, 32'h0, 4'hF);
    ack = 1'b1; rdat = 32'h0BAD_F00D;
    step();
    ack = 1'b0;
    rsp_pop("ra_rsp");
    step();

    // reset mid-RESP drops the pending response
    rsp_ready = 1'b0;
    cmd("rr", 1'b0, 32'h3000_0700, 32'h0, 4'hF);
    ack = 1'b1; rdat = 32'h5555_AAAA;
    step();
    ack = 1'b0;
    chk("rr_pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    chk("rr_dropped", 32'(rsp_valid), 32'd0);
    chk("rr_ready", 32'(cmd_ready), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
